// File: rtl/reel_pkg.sv
// reel_pkg -- shared types and constants for the reel controller.
//   state_t  : controller FSM states (IDLE, SPIN, DECEL)
//   SPEED_W  : width of the speed bus driven to the clock divider
//   sat_sub  : subtract with a lower floor, never wrapping below it
package reel_pkg;

    localparam int SPEED_W = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        DECEL = 2'd2
    } state_t;

    // a - b, clamped to floor; also clamps if b > a so no underflow wraps.
    function automatic logic [SPEED_W-1:0] sat_sub(
        input logic [SPEED_W-1:0] a,
        input logic [SPEED_W-1:0] b,
        input logic [SPEED_W-1:0] floor
    );
        if (a >= b && (a - b) >= floor)
            return a - b;
        else
            return floor;
    endfunction

endpackage

// File: rtl/reel_controller_edge_detect.sv
// edge_detect -- single-cycle pulse on each 0->1 transition of sig.
//   clk   : system clock
//   rst   : synchronous, active-low reset (clears the registered copy)
//   sig   : input level, synchronous to clk
//   pulse : high for the one clk where sig=1 and its registered copy=0
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic r_sig;

    always_ff @(posedge clk) begin
        if (!rst)
            r_sig <= 1'b0;
        else
            r_sig <= sig;
    end

    // Combinational so the consumer can act on the same clk edge,
    // giving one clk of latency from the step_clk rise to the update.
    assign pulse = sig & ~r_sig;

endmodule

// File: rtl/reel_controller.sv
// reel_controller -- slot reel spin/brake sequencer.
// Drives a step-rate request to an external clock divider and counts the
// reel position from the divider's step_clk.
//   clk      : system clock (rising edge)
//   rst      : synchronous, active-low reset
//   start    : level request to spin (honoured in IDLE only)
//   stop     : level request to brake (honoured in SPIN only)
//   step_clk : divided clock from the divider, synchronous to clk
//   speed    : requested step rate in Hz
//   symbol   : current reel position, 0..NUM_SYMBOLS-1
//   busy     : high in SPIN and DECEL
//   done     : one-clk pulse when the reel comes to rest
// Build option: REEL_CONTROLLER_DECEL_EN -- when defined the reel ramps
// down by DECEL_STEP per step while braking; otherwise it stops on the
// first step after braking begins.
module reel_controller
    import reel_pkg::*;
#(
    parameter int NUM_SYMBOLS = 8,
    parameter int MAX_SPEED   = 40,
    parameter int MIN_SPEED   = 2,
    parameter int DECEL_STEP  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           step_clk,
    output logic [SPEED_W-1:0]             speed,
    output logic [$clog2(NUM_SYMBOLS)-1:0] symbol,
    output logic                           busy,
    output logic                           done
);

    localparam int SYM_W = $clog2(NUM_SYMBOLS);
    localparam logic [SPEED_W-1:0] MAX_V  = SPEED_W'(MAX_SPEED);
    localparam logic [SPEED_W-1:0] MIN_V  = SPEED_W'(MIN_SPEED);
    localparam logic [SPEED_W-1:0] DEC_V  = SPEED_W'(DECEL_STEP);
    localparam logic [SYM_W-1:0]   LAST_V = SYM_W'(NUM_SYMBOLS - 1);

    // Reject configurations that would break wrap or the nonzero-speed rule.
    if (NUM_SYMBOLS < 2 || MIN_SPEED < 1 || MIN_SPEED > MAX_SPEED ||
        MAX_SPEED > (2**SPEED_W - 1) || DECEL_STEP < 0) begin : g_bad_cfg
        $error("reel_controller: illegal parameter combination");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic               w_step;
    logic [SYM_W-1:0]   r_symbol;
    logic [SPEED_W-1:0] r_speed;
    logic               r_done;

    edge_detect u_step_edge (
        .clk   (clk),
        .rst   (rst),
        .sig   (step_clk),
        .pulse (w_step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (start) w_next_state = SPIN;
            SPIN:  if (stop)  w_next_state = DECEL;
`ifdef REEL_CONTROLLER_DECEL_EN
            // The step taken at MIN speed is the last one.
            DECEL: if (w_step && r_speed == MIN_V) w_next_state = IDLE;
`else
            DECEL: if (w_step) w_next_state = IDLE;
`endif
            default: w_next_state = IDLE;
        endcase
    end

    // Position, speed and done registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_symbol <= '0;
            r_speed  <= MIN_V;
            r_done   <= 1'b0;
        end else begin
            // Only a real brake completion produces done; reset never does.
            r_done <= (r_state == DECEL) && (w_next_state == IDLE);

            if (r_state != IDLE && w_step)
                r_symbol <= (r_symbol == LAST_V) ? '0 : r_symbol + SYM_W'(1);

            case (r_state)
                IDLE:  r_speed <= start ? MAX_V : MIN_V;
                // SPIN holds speed, including on the step that coincides
                // with stop: braking only starts counting once in DECEL.
                SPIN:  r_speed <= r_speed;
`ifdef REEL_CONTROLLER_DECEL_EN
                DECEL: if (w_step) r_speed <= sat_sub(r_speed, DEC_V, MIN_V);
`else
                DECEL: if (w_step) r_speed <= MIN_V;
`endif
                default: r_speed <= MIN_V;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy   = (r_state != IDLE);
        speed  = r_speed;
        symbol = r_symbol;
        done   = r_done;
    end

endmodule

// File: tb/tb_reel_controller.sv
module tb_reel_controller;

    localparam int N    = 8;
    localparam int MAXS = 40;
    localparam int MINS = 2;
    localparam int DEC  = 4;

    logic        clk = 1'b0;
    logic        rst, start, stop, step_clk;
    logic [19:0] speed;
    logic [2:0]  symbol;
    logic        busy, done;

    always #5 clk = ~clk;

    reel_controller #(
        .NUM_SYMBOLS (N),
        .MAX_SPEED   (MAXS),
        .MIN_SPEED   (MINS),
        .DECEL_STEP  (DEC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .step_clk (step_clk),
        .speed    (speed),
        .symbol   (symbol),
        .busy     (busy),
        .done     (done)
    );

    // Reference model: reel mode 0=resting, 1=spinning, 2=braking.
    int m_mode, m_sym, m_spd, m_prev, m_done;
    int n_vec, n_bad, cyc, n_done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one clk using the inputs present at the edge.
    task automatic model_step();
        int ev;
        ev = (step_clk && !m_prev) ? 1 : 0;
        m_prev = step_clk ? 1 : 0;
        m_done = 0;
        if (!rst) begin
            m_mode = 0; m_sym = 0; m_spd = MINS; m_prev = 0;
        end else if (m_mode == 0) begin
            m_spd = MINS;
            if (start) begin m_mode = 1; m_spd = MAXS; end
        end else if (m_mode == 1) begin
            if (ev) m_sym = (m_sym + 1) % N;
            if (stop) m_mode = 2;
        end else begin
            if (ev) begin
                m_sym = (m_sym + 1) % N;
`ifdef REEL_CONTROLLER_DECEL_EN
                if (m_spd == MINS) begin
                    m_mode = 0; m_done = 1;
                end else begin
                    m_spd = (m_spd - DEC < MINS) ? MINS : m_spd - DEC;
                end
`else
                m_mode = 0; m_done = 1; m_spd = MINS;
`endif
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        chk({tag, ".speed"},  32'(speed),  32'(m_spd));
        chk({tag, ".symbol"}, 32'(symbol), 32'(m_sym));
        chk({tag, ".busy"},   32'(busy),   32'(m_mode != 0));
        chk({tag, ".done"},   32'(done),   32'(m_done));
        if (done === 1'b1) n_done_seen++;
    endtask

    task automatic step_edge(input string tag);
        step_clk = 1'b1; tick(tag);
        step_clk = 1'b0; tick(tag);
    endtask

    task automatic run_to_idle(input string tag);
        int guard;
        guard = 0;
        stop = 1'b1; tick(tag); stop = 1'b0;
        while (busy === 1'b1 && guard < 60) begin
            step_edge(tag);
            guard++;
        end
        chk({tag, ".idle_reached"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int nsteps, exp_steps, d0, s;
        n_vec = 0; n_bad = 0; cyc = 0; n_done_seen = 0;
        m_mode = 0; m_sym = 0; m_spd = MINS; m_prev = 0; m_done = 0;

        // Reset with start held
        rst = 1'b0; start = 1'b1; stop = 1'b0; step_clk = 1'b0;
        repeat (3) tick("reset");
        chk("rst_symbol", 32'(symbol), 32'd0);
        chk("rst_speed",  32'(speed),  32'd2);
        chk("rst_busy",   32'(busy),   32'd0);

        // One-clk start pulse, then 10 steps
        rst = 1'b1;
        tick("start");
        start = 1'b0;
        chk("spin_speed", 32'(speed), 32'd40);
        repeat (10) step_edge("spin");
        chk("spin10_speed",  32'(speed),  32'd40);
        chk("spin10_symbol", 32'(symbol), 32'd2);
        chk("spin10_busy",   32'(busy),   32'd1);

        // Wrap from 7 to 0
        repeat (5) step_edge("spin");
        chk("pre_wrap_symbol", 32'(symbol), 32'd7);
        step_edge("wrap");
        chk("wrap_symbol", 32'(symbol), 32'd0);

        // Full brake: count steps until done
`ifdef REEL_CONTROLLER_DECEL_EN
        s = MAXS; exp_steps = 1;
        while (s != MINS) begin
            s = (s - DEC < MINS) ? MINS : s - DEC;
            exp_steps++;
        end
`else
        s = MAXS; exp_steps = 1;
`endif
        stop = 1'b1; tick("brake"); stop = 1'b0;
        d0 = n_done_seen; nsteps = 0;
        while (n_done_seen == d0 && nsteps < 40) begin
            step_edge("brake");
            nsteps++;
        end
        chk("brake_steps", 32'(nsteps), 32'(exp_steps));
        repeat (4) step_edge("idle_steps");
        chk("done_pulses", 32'(n_done_seen - d0), 32'd1);
        chk("idle_speed",  32'(speed), 32'd2);

        // Step coinciding with stop must not decrement
        start = 1'b1; tick("coin"); start = 1'b0;
        stop = 1'b1; step_clk = 1'b1; tick("coin");
        stop = 1'b0; step_clk = 1'b0; tick("coin");
        chk("coin_speed", 32'(speed), 32'd40);
        run_to_idle("coin_end");

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; tick("both");
        chk("both_busy", 32'(busy), 32'd1);
        tick("both");
        start = 1'b0; stop = 1'b0;
        step_edge("both_step");
        repeat (12) step_edge("both_drain");

        // Reset mid-brake
        start = 1'b1; tick("abort"); start = 1'b0;
        repeat (3) step_edge("abort");
        stop = 1'b1; tick("abort"); stop = 1'b0;
`ifdef REEL_CONTROLLER_DECEL_EN
        repeat (2) step_edge("abort");
`endif
        chk("abort_busy_pre", 32'(busy), 32'(1));
        d0 = n_done_seen;
        rst = 1'b0; tick("abort_rst");
        chk("abort_symbol", 32'(symbol), 32'd0);
        chk("abort_speed",  32'(speed),  32'd2);
        chk("abort_busy",   32'(busy),   32'd0);
        rst = 1'b1;
        repeat (3) tick("abort_after");
        chk("abort_no_done", 32'(n_done_seen - d0), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) step_clk = ~step_clk;
            rst   = ($urandom_range(0, 199) != 0);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
